// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the fetch stage: FSM states, reset/start address
// and the constant branch-target table.
package pc_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  localparam int START_ADDR_DEF = 0;

  localparam int LUT_IDX_W = 6;
  localparam int LUT_DEPTH = 2 ** LUT_IDX_W;
  // Entries are kept wider than any practical PC; consumers take the low PC_W bits.
  localparam int LUT_W     = 16;

  localparam logic [LUT_W-1:0] BRANCH_LUT [LUT_DEPTH] = '{
    1:       16'd12,
    2:       16'd14,
    3:       16'd20,
    7:       16'd37,
    default: LUT_W'(START_ADDR_DEF)
  };

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage handshake bundle: decoder/ALU inputs, start/halt handshake
// and PC/status outputs.
interface pc_fetch_unit_if #(
  parameter int PC_W  = 10,
  parameter int IDX_W = 6,
  parameter int CNT_W = 16
);
  logic             Start;
  logic             BranchEn;
  logic             Taken;
  logic             Ack;
  logic [IDX_W-1:0] TargetIdx;
  logic [PC_W-1:0]  ProgCtr;
  logic             Running;
  logic             Done;
  logic [CNT_W-1:0] CycleCt;

  modport slave (
    input  Start, BranchEn, Taken, Ack, TargetIdx,
    output ProgCtr, Running, Done, CycleCt
  );

  modport master (
    output Start, BranchEn, Taken, Ack, TargetIdx,
    input  ProgCtr, Running, Done, CycleCt
  );
endinterface

// File: rtl/pc_fetch_unit_branch_lut.sv
// Combinational branch-target lookup: LUT index in, absolute target PC out.
module branch_lut
  import pc_fetch_unit_pkg::*;
#(
  parameter int PC_W  = 10,
  parameter int IDX_W = 6
) (
  input  logic [IDX_W-1:0] target_idx,
  output logic [PC_W-1:0]  target_pc
);

  logic [LUT_W-1:0] entry;

  always_comb begin
    entry     = BRANCH_LUT[target_idx];
    target_pc = entry[PC_W-1:0];
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencing: IDLE/RUN/HALT control, PC update
// (sequential, branch, hold) and a saturating RUN-cycle counter.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int              PC_W       = 10,
  parameter int              IDX_W      = 6,
  parameter logic [PC_W-1:0] START_ADDR = PC_W'(START_ADDR_DEF),
  parameter int              CNT_W      = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  pc_fetch_unit_if.slave bus
);

  fetch_state_e     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             running_q, running_d;
  logic             done_q, done_d;
  logic [PC_W-1:0]  target_pc;

  branch_lut #(
    .PC_W  (PC_W),
    .IDX_W (IDX_W)
  ) u_branch_lut (
    .target_idx (bus.TargetIdx),
    .target_pc  (target_pc)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE, ST_HALT: begin
        if (bus.Start) begin
          state_d = ST_RUN;
          pc_d    = START_ADDR;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        // The halt cycle itself is counted; the counter sticks at all-ones.
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (bus.Ack) begin
          state_d = ST_HALT;
        end else if (bus.BranchEn && bus.Taken) begin
          pc_d = target_pc;
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        pc_d    = START_ADDR;
        cnt_d   = '0;
      end
    endcase
    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_HALT);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= START_ADDR;
      cnt_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign bus.ProgCtr = pc_q;
  assign bus.Running = running_q;
  assign bus.Done    = done_q;
  assign bus.CycleCt = cnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: vector table plus hand sequences for
// async reset, halt, start-under-reset, and PC wrap / counter saturation.
module tb_pc_fetch_unit;

  logic Clk;
  logic Reset;

  pc_fetch_unit_if #(.PC_W(10), .IDX_W(6), .CNT_W(16)) bus ();
  pc_fetch_unit_if #(.PC_W(4),  .IDX_W(6), .CNT_W(3))  sbus ();

  pc_fetch_unit #(.PC_W(10), .IDX_W(6), .START_ADDR(10'd0), .CNT_W(16)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  pc_fetch_unit #(.PC_W(4), .IDX_W(6), .START_ADDR(4'd0), .CNT_W(3)) dut_small (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (sbus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        start;
    logic        br;
    logic        tk;
    logic        ack;
    logic [5:0]  idx;
    logic [9:0]  pc;
    logic        run;
    logic        done;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs [12];
  int   checks;
  int   errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic b, input logic t, input logic a, input logic [5:0] i);
    bus.Start     = s;
    bus.BranchEn  = b;
    bus.Taken     = t;
    bus.Ack       = a;
    bus.TargetIdx = i;
  endtask

  task automatic check_big(input string tag, input logic [9:0] pc, input logic run,
                           input logic done, input logic [15:0] cnt);
    check({tag, ".pc"},   32'(bus.ProgCtr), 32'(pc));
    check({tag, ".run"},  32'(bus.Running), 32'(run));
    check({tag, ".done"}, 32'(bus.Done),    32'(done));
    check({tag, ".cnt"},  32'(bus.CycleCt), 32'(cnt));
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Reset  = 1'b1;
    drive(0, 0, 0, 0, 6'd0);
    sbus.Start = 0; sbus.BranchEn = 0; sbus.Taken = 0; sbus.Ack = 0; sbus.TargetIdx = '0;

    //         start br tk ack idx   pc  run done cnt
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 10'd0,  1'b1, 1'b0, 16'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 10'd1,  1'b1, 1'b0, 16'd1};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 10'd2,  1'b1, 1'b0, 16'd2};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 6'd3, 10'd3,  1'b1, 1'b0, 16'd3};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 6'd3, 10'd20, 1'b1, 1'b0, 16'd4};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 10'd21, 1'b1, 1'b0, 16'd5};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 6'd3, 10'd21, 1'b0, 1'b1, 16'd6};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 6'd3, 10'd21, 1'b0, 1'b1, 16'd6};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 10'd0,  1'b1, 1'b0, 16'd0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 10'd1,  1'b1, 1'b0, 16'd1};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 6'd1, 10'd12, 1'b1, 1'b0, 16'd2};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 10'd12, 1'b0, 1'b1, 16'd3};

    // Start held high while in reset: no acceptance until the first edge after release.
    drive(1, 0, 0, 0, 6'd0);
    step();
    step();
    check("rst_hold.pc",   32'(bus.ProgCtr), 32'd0);
    check("rst_hold.run",  32'(bus.Running), 32'd0);
    check("rst_hold.done", 32'(bus.Done),    32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    check("rst_rel.run", 32'(bus.Running), 32'd0);
    step();
    check_big("first_edge", 10'd0, 1'b1, 1'b0, 16'd0);
    drive(0, 0, 0, 0, 6'd0);
    step();
    check_big("first_edge+1", 10'd1, 1'b1, 1'b0, 16'd1);

    // Table-driven vectors from a clean IDLE.
    do_reset();
    check_big("idle", 10'd0, 1'b0, 1'b0, 16'd0);
    step();
    check_big("idle_ignore", 10'd0, 1'b0, 1'b0, 16'd0);
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].start, vecs[i].br, vecs[i].tk, vecs[i].ack, vecs[i].idx);
      step();
      check_big($sformatf("vec%0d", i), vecs[i].pc, vecs[i].run, vecs[i].done, vecs[i].cnt);
    end

    // Ack when PC reaches 5: PC holds, Done next cycle, count 6.
    drive(0, 0, 0, 0, 6'd0);
    do_reset();
    drive(1, 0, 0, 0, 6'd0);
    step();
    drive(0, 0, 0, 0, 6'd0);
    for (int p = 0; p < 5; p++) begin
      check($sformatf("seq.pc%0d", p), 32'(bus.ProgCtr), 32'(p));
      step();
    end
    check("seq.pc5", 32'(bus.ProgCtr), 32'd5);
    drive(0, 0, 0, 1, 6'd0);
    step();
    check_big("ack5", 10'd5, 1'b0, 1'b1, 16'd6);
    drive(0, 0, 0, 0, 6'd0);
    step();
    check_big("ack5_hold", 10'd5, 1'b0, 1'b1, 16'd6);

    // Async reset mid-RUN at PC=37.
    drive(1, 0, 0, 0, 6'd0);
    step();
    drive(0, 1, 1, 0, 6'd7);
    step();
    check_big("pre_rst", 10'd37, 1'b1, 1'b0, 16'd1);
    drive(0, 0, 0, 0, 6'd0);
    #2;
    Reset = 1'b1;
    #1;
    check_big("async_rst", 10'd0, 1'b0, 1'b0, 16'd0);
    @(negedge Clk);
    Reset = 1'b0;
    step();
    check_big("post_rst_idle", 10'd0, 1'b0, 1'b0, 16'd0);

    // Narrow instance: branch to 14 then wrap PC and saturate the 3-bit counter.
    sbus.Start = 1'b1;
    step();
    sbus.Start = 1'b0;
    check("s.start.pc",  32'(sbus.ProgCtr), 32'd0);
    check("s.start.run", 32'(sbus.Running), 32'd1);
    sbus.BranchEn = 1'b1; sbus.Taken = 1'b1; sbus.TargetIdx = 6'd2;
    step();
    sbus.BranchEn = 1'b0; sbus.Taken = 1'b0; sbus.TargetIdx = 6'd0;
    check("s.br.pc",  32'(sbus.ProgCtr), 32'd14);
    check("s.br.cnt", 32'(sbus.CycleCt), 32'd1);
    begin
      int exp_pc [8]  = '{15, 0, 1, 2, 3, 4, 5, 6};
      int exp_cnt [8] = '{2, 3, 4, 5, 6, 7, 7, 7};
      for (int k = 0; k < 8; k++) begin
        step();
        check($sformatf("s.wrap%0d.pc", k),  32'(sbus.ProgCtr), 32'(exp_pc[k]));
        check($sformatf("s.wrap%0d.cnt", k), 32'(sbus.CycleCt), 32'(exp_cnt[k]));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
